y86_bus_memory: RTL

- Memory responder on the far end of the y86 sequential core's memory bus (bus_A / bus_in / bus_out / bus_WE / bus_RE).
- Serves instruction fetches and mov loads/stores over one byte-addressed, little-endian store, with zero wait states.
- Contains a LOAD/RUN state machine: a program loader fills memory while the core is held, then the core is released into RUN.
- Keeps sticky protocol-error status and access counters for testbench and debug visibility.

---
 rtl/y86_bus_pkg.sv | 20 ++
 rtl/y86_bus_if.sv | 13 +
 rtl/y86_byte_ram4.sv | 32 +++
 rtl/y86_bus_memory.sv | 84 ++++++++
 4 files changed

// File: rtl/y86_bus_pkg.sv
// Shared definitions for the y86 memory bus responder: loader/run states,
// default geometry and the opcode bytes the core decodes.
package y86_bus_pkg;

  localparam int AW_DEFAULT = 12;
  localparam int CW_DEFAULT = 16;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] OP_MOV_STORE = 8'h89;
  localparam logic [7:0] OP_MOV_LOAD  = 8'h8B;
  localparam logic [7:0] OP_ADD       = 8'h01;
  localparam logic [7:0] OP_SUB       = 8'h29;
  localparam logic [7:0] OP_JNEZ      = 8'h75;
  localparam logic [7:0] OP_HLT       = 8'hF4;

endpackage

// File: rtl/y86_bus_if.sv
// Core-to-memory bus: byte address, store data, read data and the two strobes.
interface y86_bus_if;

  logic [31:0] bus_A;
  logic [31:0] bus_out;
  logic [31:0] bus_in;
  logic        bus_WE;
  logic        bus_RE;

  modport master (output bus_A, output bus_out, output bus_WE, output bus_RE, input bus_in);
  modport slave  (input bus_A, input bus_out, input bus_WE, input bus_RE, output bus_in);

endinterface

// File: rtl/y86_byte_ram4.sv
// Byte-wide store with a 4-byte unaligned combinational read and a 4-byte
// synchronous write; byte lanes wrap modulo 2**AW.
module y86_byte_ram4 #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [2**AW];

  // AW-bit sums give the wrap past the top address for free.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rdata[8*gi +: 8] = mem[raddr + AW'(gi)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        mem[waddr + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/y86_bus_memory.sv
// Zero-wait-state memory responder for the y86 core: a loader fills memory
// while the core is held, then bus reads/writes are served in RUN.
module y86_bus_memory
  import y86_bus_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  y86_bus_if.slave      bus,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_done,
  output logic          cpu_hold,
  output logic          err,
  output logic [CW-1:0] rd_count,
  output logic [CW-1:0] wr_count
);

  state_t        state_reg;
  logic          err_reg;
  logic [CW-1:0] rd_count_reg;
  logic [CW-1:0] wr_count_reg;

  logic          run;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          unused_addr_hi;

  assign run            = (state_reg == RUN);
  assign unused_addr_hi = ^bus.bus_A[31:AW];

  // A write still pending when rst rises must not land in memory.
  assign ram_we    = !rst && (run ? bus.bus_WE : ld_valid);
  assign ram_waddr = run ? bus.bus_A[AW-1:0] : ld_addr;
  assign ram_wdata = run ? bus.bus_out : ld_data;

  y86_byte_ram4 #(
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus.bus_A[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.bus_in = (run && bus.bus_RE) ? ram_rdata : 32'h0;
  assign cpu_hold   = !run;
  assign ld_ready   = !run;
  assign err        = err_reg;
  assign rd_count   = rd_count_reg;
  assign wr_count   = wr_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= LOAD;
      err_reg      <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else if (state_reg == LOAD) begin
      if (ld_done) begin
        state_reg <= RUN;
      end
    end else begin
      if (bus.bus_RE && bus.bus_WE) begin
        err_reg <= 1'b1;
      end
      if (bus.bus_RE && (rd_count_reg != '1)) begin
        rd_count_reg <= rd_count_reg + CW'(1);
      end
      if (bus.bus_WE && (wr_count_reg != '1)) begin
        wr_count_reg <= wr_count_reg + CW'(1);
      end
    end
  end

endmodule
